// File: rtl/jogo_unidade_controle_if.sv
// Signal bundle between the memory-game control unit and its datapath.
// The slave modport is the control unit; the master modport is the datapath side.
interface jogo_unidade_controle_if;
    logic       iniciar;
    logic       jogada_feita;
    logic       igual;
    logic       enderecoIgualSequencia;
    logic       fimE;
    logic       controle_timeout;
    logic       zeraE;
    logic       contaE;
    logic       zeraS;
    logic       contaS;
    logic       zeraR;
    logic       registraR;
    logic       zeraT;
    logic       contaT;
    logic       pronto;
    logic       ganhou;
    logic       perdeu;
    logic       timeout;
    logic [4:0] db_estado;

    modport master (
        output iniciar, jogada_feita, igual, enderecoIgualSequencia, fimE, controle_timeout,
        input  zeraE, contaE, zeraS, contaS, zeraR, registraR, zeraT, contaT,
        input  pronto, ganhou, perdeu, timeout, db_estado
    );

    modport slave (
        input  iniciar, jogada_feita, igual, enderecoIgualSequencia, fimE, controle_timeout,
        output zeraE, contaE, zeraS, contaS, zeraR, registraR, zeraT, contaT,
        output pronto, ganhou, perdeu, timeout, db_estado
    );
endinterface

// File: rtl/jogo_unidade_controle.sv
// Moore control FSM for the memory game: sequences rounds, compares moves and
// reports win/loss/timeout. State codes are fixed for the 7-segment debug display.
module jogo_unidade_controle (
    input logic                    clock,
    input logic                    reset,
    jogo_unidade_controle_if.slave bus
);

    localparam logic [4:0] INICIAL           = 5'h00;
    localparam logic [4:0] PREPARACAO        = 5'h01;
    localparam logic [4:0] INICIA_SEQUENCIA  = 5'h02;
    localparam logic [4:0] ESPERA_JOGADA     = 5'h03;
    localparam logic [4:0] REGISTRA          = 5'h04;
    localparam logic [4:0] COMPARACAO        = 5'h05;
    localparam logic [4:0] PROXIMA_JOGADA    = 5'h06;
    localparam logic [4:0] PROXIMA_SEQUENCIA = 5'h07;
    localparam logic [4:0] FIM_ACERTOU       = 5'h0A;
    localparam logic [4:0] FIM_ERROU         = 5'h0E;
    localparam logic [4:0] FIM_TIMEOUT       = 5'h0F;

    logic [4:0] r_estado;
    logic [4:0] w_estado_prox;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_estado <= INICIAL;
        end else begin
            r_estado <= w_estado_prox;
        end
    end

    always_comb begin
        w_estado_prox = INICIAL;
        case (r_estado)
            INICIAL:           w_estado_prox = bus.iniciar ? PREPARACAO : INICIAL;
            PREPARACAO:        w_estado_prox = INICIA_SEQUENCIA;
            INICIA_SEQUENCIA:  w_estado_prox = ESPERA_JOGADA;
            // A move in the same cycle as the timeout still counts as a move.
            ESPERA_JOGADA: begin
                if (bus.jogada_feita) begin
                    w_estado_prox = REGISTRA;
                end else if (bus.controle_timeout) begin
                    w_estado_prox = FIM_TIMEOUT;
                end else begin
                    w_estado_prox = ESPERA_JOGADA;
                end
            end
            REGISTRA:          w_estado_prox = COMPARACAO;
            COMPARACAO: begin
                if (!bus.igual) begin
                    w_estado_prox = FIM_ERROU;
                end else if (!bus.enderecoIgualSequencia) begin
                    w_estado_prox = PROXIMA_JOGADA;
                end else if (bus.fimE) begin
                    w_estado_prox = FIM_ACERTOU;
                end else begin
                    w_estado_prox = PROXIMA_SEQUENCIA;
                end
            end
            PROXIMA_JOGADA:    w_estado_prox = ESPERA_JOGADA;
            PROXIMA_SEQUENCIA: w_estado_prox = INICIA_SEQUENCIA;
            FIM_ACERTOU:       w_estado_prox = bus.iniciar ? PREPARACAO : FIM_ACERTOU;
            FIM_ERROU:         w_estado_prox = bus.iniciar ? PREPARACAO : FIM_ERROU;
            FIM_TIMEOUT:       w_estado_prox = bus.iniciar ? PREPARACAO : FIM_TIMEOUT;
            default:           w_estado_prox = INICIAL;
        endcase
    end

    always_comb begin
        bus.zeraE     = 1'b0;
        bus.contaE    = 1'b0;
        bus.zeraS     = 1'b0;
        bus.contaS    = 1'b0;
        bus.zeraR     = 1'b0;
        bus.registraR = 1'b0;
        bus.zeraT     = 1'b0;
        bus.contaT    = 1'b0;
        bus.pronto    = 1'b0;
        bus.ganhou    = 1'b0;
        bus.perdeu    = 1'b0;
        bus.timeout   = 1'b0;
        case (r_estado)
            INICIAL, PREPARACAO: begin
                bus.zeraE = 1'b1;
                bus.zeraS = 1'b1;
                bus.zeraR = 1'b1;
                bus.zeraT = 1'b1;
            end
            INICIA_SEQUENCIA: begin
                bus.zeraE = 1'b1;
                bus.zeraT = 1'b1;
            end
            ESPERA_JOGADA:     bus.contaT    = 1'b1;
            REGISTRA:          bus.registraR = 1'b1;
            // Clearing the timer on each accepted move gives a per-move time budget.
            PROXIMA_JOGADA: begin
                bus.contaE = 1'b1;
                bus.zeraT  = 1'b1;
            end
            PROXIMA_SEQUENCIA: begin
                bus.contaS = 1'b1;
                bus.zeraT  = 1'b1;
            end
            FIM_ACERTOU: begin
                bus.pronto = 1'b1;
                bus.ganhou = 1'b1;
            end
            FIM_ERROU: begin
                bus.pronto = 1'b1;
                bus.perdeu = 1'b1;
            end
            FIM_TIMEOUT: begin
                bus.pronto  = 1'b1;
                bus.timeout = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.db_estado = r_estado;

endmodule

// File: doc/jogo_unidade_controle.md
Name: jogo_unidade_controle

Overview:
- Control unit (Moore FSM) for the memory game ("Jogo da Memória"). It drives the game datapath: address/sequence counters, button register and timeout counter.
- Consumes the datapath status flags: igual, fimE, enderecoIgualSequencia, jogada_feita, controle_timeout.
- Sequences the game rounds: each round replays a sequence that grows by one, and the game ends in win, loss or timeout.
- Exports game-status and debug outputs to the top level.

Parameters:
- None. State encoding is fixed (see Behaviour) so db_estado is stable for the 7-seg debug display.

Ports:
- clock  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; forces state inicial on next rising edge
- iniciar  input  1  start/restart request (level)
- jogada_feita  input  1  one-cycle pulse from the datapath edge detector
- igual  input  1  ROM data == registered buttons
- enderecoIgualSequencia  input  1  address counter == sequence counter
- fimE  input  1  address at last position for the current level (nivel-muxed in datapath)
- controle_timeout  input  1  timeout counter reached end
- zeraE  output  1  clear address counter
- contaE  output  1  increment address counter
- zeraS  output  1  clear sequence counter
- contaS  output  1  increment sequence counter
- zeraR  output  1  clear button register
- registraR  output  1  load button register
- zeraT  output  1  clear timeout counter (sync)
- contaT  output  1  enable timeout counter
- pronto  output  1  game finished (any end state)
- ganhou  output  1  finished by completing the last sequence
- perdeu  output  1  finished by wrong button
- timeout  output  1  finished by timeout
- db_estado  output  5  current state code

Behaviour:
- Single state register, updated on rising clock edge. All outputs are pure combinational decode of the state (Moore); no input-to-output paths.
- Reset takes priority over every transition. After reset: state = inicial, db_estado = 5'h00. Outputs: zeraE = zeraS = zeraR = zeraT = 1, all others 0. Reset asserted mid-game aborts the game the next edge.
- State codes: inicial 00, preparacao 01, inicia_sequencia 02, espera_jogada 03, registra 04, comparacao 05, proxima_jogada 06, proxima_sequencia 07, fim_acertou 0A, fim_errou 0E, fim_timeout 0F. Unused codes go to inicial on the next edge.
- Outputs asserted per state (all unlisted outputs = 0):
  - inicial: zeraE, zeraS, zeraR, zeraT
  - preparacao: zeraE, zeraS, zeraR, zeraT
  - inicia_sequencia: zeraE, zeraT
  - espera_jogada: contaT
  - registra: registraR
  - comparacao: none
  - proxima_jogada: contaE, zeraT
  - proxima_sequencia: contaS, zeraT
  - fim_acertou: pronto, ganhou
  - fim_errou: pronto, perdeu
  - fim_timeout: pronto, timeout
- Transitions:
  - inicial: iniciar -> preparacao; else stay.
  - preparacao -> inicia_sequencia (unconditional).
  - inicia_sequencia -> espera_jogada.
  - espera_jogada: jogada_feita -> registra; else controle_timeout -> fim_timeout; else stay. If both are high in the same cycle, jogada_feita wins.
  - registra -> comparacao. This gives a one-cycle latency so the register output and igual are valid in comparacao.
  - comparacao, in priority order:
    - !igual -> fim_errou
    - igual & !enderecoIgualSequencia -> proxima_jogada
    - igual & enderecoIgualSequencia & fimE -> fim_acertou
    - igual & enderecoIgualSequencia & !fimE -> proxima_sequencia
  - proxima_jogada -> espera_jogada.
  - proxima_sequencia -> inicia_sequencia.
  - fim_acertou / fim_errou / fim_timeout: iniciar -> preparacao; else stay. The result flags hold until restart.
- Latency:
  - Press to verdict: jogada_feita at edge k -> registra at k+1 -> comparacao at k+2 -> result state at k+3.
  - iniciar to first espera_jogada: 3 edges.
- Inputs in states that do not sample them are ignored: jogada_feita outside espera_jogada, and controle_timeout outside espera_jogada.
- The timeout counter is cleared on every accepted move, so the time budget applies per move, not per round.

Test Plan:
- Reset/idle: reset=1 for 2 cycles, then iniciar=0 for 5 cycles -> db_estado=00, zeraE=zeraS=zeraR=zeraT=1, pronto=0 throughout.
- Start: iniciar pulse from inicial -> db_estado sequence 01,02,03 on consecutive edges. In state 03, contaT=1 and all other control outputs are 0.
- Correct first round, not last: in espera_jogada, pulse jogada_feita with igual=1, enderecoIgualSequencia=1, fimE=0 -> states 04,05,07,02,03. contaS=1 for exactly one cycle.
- Mid-sequence correct then wrong: jogada with igual=1, enderecoIgualSequencia=0 -> 04,05,06,03 with contaE one cycle. Next jogada with igual=0 -> 04,05,0E. Then pronto=1, perdeu=1, held 10 cycles until iniciar -> 01.
- Win and timeout: comparacao with igual=1, enderecoIgualSequencia=1, fimE=1 -> 0A, ganhou=1. Separately, controle_timeout=1 in espera_jogada -> 0F, timeout=1. If jogada_feita=1 and controle_timeout=1 in the same cycle -> 04 (not 0F).
- Reset mid-game: assert reset while in comparacao or fim_acertou -> db_estado=00 on the next edge, all status outputs 0.
